// File: rtl/qos_wrr_sched.sv
// qos_wrr_sched: weighted round-robin pick among 4 class FIFOs, steering the popped word to its egress FIFO.
module qos_wrr_sched #(
    parameter int DW       = 12,
    parameter int DEST_LSB = 8,
    parameter int WW       = 4,
    parameter int SW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [WW-1:0] weight0,
    input  logic [WW-1:0] weight1,
    input  logic [WW-1:0] weight2,
    input  logic [WW-1:0] weight3,
    input  logic [3:0]    empty,
    input  logic [DW-1:0] head0,
    input  logic [DW-1:0] head1,
    input  logic [DW-1:0] head2,
    input  logic [DW-1:0] head3,
    input  logic [3:0]    almost_full,
    output logic [3:0]    pop,
    output logic [3:0]    push,
    output logic [DW-1:0] data_out,
    output logic [SW-1:0] stall_cnt,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ARB, BLOCK} state_t;
    state_t        r_state;
    logic [1:0]    r_rr;
    logic [WW-1:0] r_w  [4];
    logic [WW-1:0] r_cr [4];
    logic [WW-1:0] w_win [4];
    logic [DW-1:0] w_head [4];
    logic [3:0]    w_pend, w_elig;
    logic [1:0]    w_g, w_idx, w_dest;
    logic          w_gv, w_blocked;
    always_comb begin
        w_win  = '{weight0, weight1, weight2, weight3};
        w_head = '{head0, head1, head2, head3};
        for (int c = 0; c < 4; c++) begin
            w_pend[c] = !empty[c] && r_w[c] != '0;
            w_elig[c] = w_pend[c] && !almost_full[w_head[c][DEST_LSB+1:DEST_LSB]];
        end
        w_g   = r_rr;
        w_gv  = 1'b0;
        w_idx = '0;
        // Scan downwards so the class closest to rr_ptr overrides the rest
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_rr + 2'(i);
            if (w_elig[w_idx]) begin
                w_g  = w_idx;
                w_gv = 1'b1;
            end
        end
        w_gv      = w_gv && enable && !cfg_load && r_state != IDLE;
        w_dest    = w_head[w_g][DEST_LSB+1:DEST_LSB];
        w_blocked = |w_pend && !(|w_elig);
    end
    assign pop  = w_gv ? 4'b0001 << w_g : 4'b0000;
    assign busy = r_state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_w       <= '{default: WW'(1)};
            r_cr      <= '{default: WW'(1)};
            push      <= '0;
            data_out  <= '0;
            stall_cnt <= '0;
        end else begin
            push <= w_gv ? 4'b0001 << w_dest : 4'b0000;
            if (w_gv) begin
                data_out <= w_head[w_g];
                if (r_cr[w_g] > WW'(1)) begin
                    r_cr[w_g] <= r_cr[w_g] - 1'b1;
                    r_rr      <= w_g;
                end else begin
                    r_cr[w_g] <= r_w[w_g];
                    r_rr      <= w_g + 2'd1;
                end
            end
            if (cfg_load) begin
                r_w  <= w_win;
                r_cr <= w_win;
                r_rr <= '0;
            end
            case (r_state)
                IDLE: if (enable) begin
                    r_state   <= ARB;
                    stall_cnt <= '0;
                end
                ARB: r_state <= !enable ? IDLE : w_blocked ? BLOCK : ARB;
                BLOCK: begin
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
                    r_state <= !enable ? IDLE : w_blocked ? BLOCK : ARB;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
